pla_sweep_capture: RTL and testbench
====================================

// Module: pla_sweep_capture
// PURPOSE
//  Exhaustive stimulus/capture stage around a single-output combinational PLA netlist (x0..x8 -> y0).
//  Walks all 2^N_IN input vectors on x_out and samples the PLA's y_in one cycle later.
//  Packs the results into truth-table words on a valid/ready stream and counts onset minterms.
//  Feeds the restriction/autosymmetry checker downstream.
// PARAMETERS
//  N_IN   9   number of PLA inputs; sweep length 2^N_IN
//  OUT_W  32  truth-table word width; must divide 2^N_IN and be >= 2
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  start        in   1        begin sweep; sampled only in IDLE
//  busy         out  1        high in SWEEP and DRAIN
//  done         out  1        one-cycle pulse after the last word is accepted
//  x_out        out  N_IN     vector driven to the PLA inputs; x_out[0] = x0
//  y_in         in   1        PLA output y0; combinational from x_out, settles within one cycle
//  tt_valid     out  1        truth-table word available
//  tt_ready     in   1        downstream accepts the word
//  tt_data      out  OUT_W    bit j = y for vector (word_idx*OUT_W + j)
//  tt_last      out  1        qualifies the final word
//  onset_count  out  N_IN+1   number of vectors with y=1
//  sig_out      out  16       MISR signature (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; x_out, tt_data, onset_count, sig_out = 0; busy, done, tt_valid, tt_last = 0.
//  - Reset mid-sweep discards everything, including any partial word. Nothing is emitted afterwards.
//  - FSM states are IDLE, SWEEP, DRAIN, DONE.
//  - IDLE --start--> SWEEP: at that edge, idx=0, x_out=0, onset_count=0 and pack register=0.
//  - start is ignored in every state except IDLE.
//  - SWEEP, each non-stalled edge:
//      - pack[idx%OUT_W] <= y_in (this samples the PLA for x_out from the previous edge);
//      - onset_count += y_in;
//      - idx and x_out advance by 1.
//  - Word completion, when idx%OUT_W == OUT_W-1:
//      - the completed word loads into tt_data and tt_valid goes high on the next cycle;
//      - tt_last = (idx == 2^N_IN-1).
//  - Stall: a word completes while tt_valid && !tt_ready. On that edge nothing samples and idx/x_out hold.
//    The sweep resumes on the edge of the handshake, so no data is lost or duplicated.
//  - Handshake: the transfer happens on an edge with tt_valid && tt_ready.
//    tt_data and tt_last stay stable while tt_valid is high and not yet accepted.
//  - After the last vector is sampled, the state goes to DRAIN.
//    The tt_last handshake moves the state to DONE, where done=1 for one cycle, then back to IDLE.
//  - onset_count and the last tt_data hold until the next start.
//  - Latency: with tt_ready=1 throughout, done is high 2^N_IN+1 edges after the edge that accepted start.
//    Words come out every OUT_W cycles.
//  - onset_count cannot overflow: its width N_IN+1 holds 2^N_IN.
// CONFIGURATION
//  - SWEEP_SIG_EN defined: a 16-bit MISR (poly x^16+x^12+x^5+1, seed 0xFFFF at start) absorbs y_in on every sampling edge.
//    sig_out holds the final value from DONE until the next start.
//  - SWEEP_SIG_EN undefined: no MISR logic; sig_out is tied to 16'h0000.
// STRUCTURE
//  - Package sweep_pkg: state enum sweep_state_t (IDLE/SWEEP/DRAIN/DONE) and MISR polynomial/seed constants.
//    It also holds the function words_per_sweep(N_IN, OUT_W).
//  - Sub-module sweep_misr (clk, rst_n, clear, en, din, sig); instantiated only under SWEEP_SIG_EN.
//  - Top level: FSM, counter, pack register and output skid register.
// TESTING
//  1. PLA model y=0, tt_ready=1 -> 16 words of 0x00000000; tt_last only on word 15; onset_count=0;
//     done at +513 edges.
//  2. PLA model y=1 -> 16 words of 0xFFFFFFFF; onset_count=512.
//  3. PLA model y=x0 -> every word is 0xAAAAAAAA; onset_count=256.
//     PLA model y=x8 -> words 0..7 = 0, words 8..15 = 0xFFFFFFFF.
//  4. tt_ready=0 from start -> word 0 valid and held; x_out freezes at 63.
//     Release after 100 cycles -> words identical to test 3; no vector skipped.
//  5. start pulsed during SWEEP -> ignored.
//     rst_n low at x_out=200 -> all outputs 0, no tt_valid; a fresh start reproduces test 3 exactly.
//  6. Real PLA netlist instantiated -> tt_data matches the golden truth table word-by-word.
//     With SWEEP_SIG_EN, sig_out equals the model MISR; without it, sig_out=0.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and constants for the PLA sweep/capture stage.
// Holds the FSM state enum, the MISR polynomial/seed and a sizing helper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // x^16 + x^12 + x^5 + 1, taps for a left-shifting register
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    // Number of truth-table words produced by one full sweep
    function automatic int unsigned words_per_sweep(input int unsigned n_in,
                                                    input int unsigned out_w);
        return (32'd1 << n_in) / out_w;
    endfunction

endpackage

// File: rtl/sweep_misr.sv
// 16-bit serial signature register absorbing one response bit per enable.
// clear reloads the seed and takes priority over en.
module sweep_misr
    import sweep_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] sig
);

    logic [15:0] sig_q;
    logic [15:0] sig_d;
    logic        fb;

    // Next signature: seed on clear, otherwise shift with feedback from MSB xor input
    always_comb begin
        sig_d = sig_q;
        fb    = sig_q[15] ^ din;
        if (clear) begin
            sig_d = MISR_SEED;
        end else if (en) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (fb ? MISR_POLY : 16'h0000);
        end
    end

    // Signature register, cleared to zero by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/pla_sweep_capture.sv
// Exhaustive stimulus/capture stage for a single-output PLA.
// Drives every input vector on x_out, samples y_in one cycle later, packs the
// responses into truth-table words on a valid/ready stream and counts onset minterms.
// Optional signature: define SWEEP_SIG_EN to build the MISR behind sig_out;
// otherwise sig_out is tied to zero.
module pla_sweep_capture
    import sweep_pkg::*;
#(
    parameter int unsigned N_IN  = 9,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [N_IN-1:0]  x_out,
    input  logic             y_in,
    output logic             tt_valid,
    input  logic             tt_ready,
    output logic [OUT_W-1:0] tt_data,
    output logic             tt_last,
    output logic [N_IN:0]    onset_count,
    output logic [15:0]      sig_out
);

    localparam int unsigned BW = $clog2(OUT_W);

    sweep_state_t     state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [OUT_W-1:0] pack_q, pack_d;
    logic [OUT_W-1:0] word;
    logic [OUT_W-1:0] tt_data_q, tt_data_d;
    logic             tt_valid_q, tt_valid_d;
    logic             tt_last_q, tt_last_d;
    logic [N_IN:0]    onset_q, onset_d;

    logic             word_end;
    logic             vec_last;
    logic             handshake;
    logic             stall;

    assign word_end  = (idx_q[BW-1:0] == BW'(OUT_W - 1));
    assign vec_last  = &idx_q;
    assign handshake = tt_valid_q && tt_ready;
    // A finished word cannot be parked while the skid register is still occupied
    assign stall     = word_end && tt_valid_q && !tt_ready;

    // Next-state and datapath: sequencing, packing, counting and the output skid register
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pack_d     = pack_q;
        tt_data_d  = tt_data_q;
        tt_valid_d = tt_valid_q;
        tt_last_d  = tt_last_q;
        onset_d    = onset_q;

        // Current word with the bit for the vector presented last cycle filled in
        word                 = pack_q;
        word[idx_q[BW-1:0]]  = y_in;

        if (handshake) begin
            tt_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    pack_d  = '0;
                    onset_d = '0;
                end
            end
            SWEEP: begin
                if (!stall) begin
                    pack_d  = word;
                    onset_d = onset_q + (N_IN + 1)'(y_in);
                    idx_d   = idx_q + N_IN'(1);
                    if (word_end) begin
                        tt_data_d  = word;
                        tt_valid_d = 1'b1;
                        tt_last_d  = vec_last;
                        if (vec_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (handshake && tt_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any sweep in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pack_q     <= '0;
            tt_data_q  <= '0;
            tt_valid_q <= 1'b0;
            tt_last_q  <= 1'b0;
            onset_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            tt_data_q  <= tt_data_d;
            tt_valid_q <= tt_valid_d;
            tt_last_q  <= tt_last_d;
            onset_q    <= onset_d;
        end
    end

    assign busy        = (state_q == SWEEP) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign x_out       = idx_q;
    assign tt_valid    = tt_valid_q;
    assign tt_data     = tt_data_q;
    assign tt_last     = tt_last_q;
    assign onset_count = onset_q;

`ifdef SWEEP_SIG_EN
    logic misr_clear;
    logic misr_en;

    // Seed on the accepting edge, absorb y_in on exactly the edges that sample it
    assign misr_clear = (state_q == IDLE) && start;
    assign misr_en    = (state_q == SWEEP) && !stall;

    sweep_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (misr_clear),
        .en    (misr_en),
        .din   (y_in),
        .sig   (sig_out)
    );
`else
    assign sig_out = 16'h0000;
`endif

endmodule

// File: tb/tb_pla_sweep_capture.sv
// Self-checking bench for pla_sweep_capture with a behavioural PLA on x_out/y_in.
// Expected words are pushed to a scoreboard per sweep and compared against captured output.
module tb_pla_sweep_capture;
    import sweep_pkg::*;

    localparam int WORDS = words_per_sweep(9, 32);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tt_ready = 1'b1;
    logic        busy, done, y_in, tt_valid, tt_last;
    logic [8:0]  x_out;
    logic [31:0] tt_data;
    logic [9:0]  onset_count;
    logic [15:0] sig_out;

    int errors = 0;
    int checks = 0;
    int mode = 0;

    logic [31:0] exp_q[$];
    logic        exp_last_q[$];
    logic [31:0] got_q[$];
    logic        got_last_q[$];

    always #5 clk = ~clk;

    pla_sweep_capture #(.N_IN(9), .OUT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .x_out       (x_out),
        .y_in        (y_in),
        .tt_valid    (tt_valid),
        .tt_ready    (tt_ready),
        .tt_data     (tt_data),
        .tt_last     (tt_last),
        .onset_count (onset_count),
        .sig_out     (sig_out)
    );

    function automatic logic pla_eval(input int m, input logic [8:0] v);
        case (m)
            0: return 1'b0;
            1: return 1'b1;
            2: return v[0];
            3: return v[8];
            default: return (v[0] & v[1] & ~v[2]) | (~v[3] & v[4] & v[5]) |
                            (v[6] & ~v[7] & v[8]) | (v[2] & v[5] & v[8]) |
                            (~v[0] & ~v[4] & v[7]);
        endcase
    endfunction

    assign y_in = pla_eval(mode, x_out);

    function automatic int model_onset(input int m);
        int n = 0;
        for (int v = 0; v < 512; v++) n += int'(pla_eval(m, 9'(v)));
        return n;
    endfunction

    function automatic logic [15:0] model_sig(input int m);
        logic [15:0] s = 16'hFFFF;
        logic        fb;
        for (int v = 0; v < 512; v++) begin
            fb = s[15] ^ pla_eval(m, 9'(v));
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    task automatic push_expected(input int m);
        logic [31:0] w;
        exp_q.delete();
        exp_last_q.delete();
        got_q.delete();
        got_last_q.delete();
        for (int k = 0; k < WORDS; k++) begin
            for (int j = 0; j < 32; j++) w[j] = pla_eval(m, 9'(k * 32 + j));
            exp_q.push_back(w);
            exp_last_q.push_back(k == WORDS - 1);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Capture words with tt_ready high until done or the cycle budget expires
    task automatic collect(output int done_at);
        done_at = -1;
        tt_ready = 1'b1;
        for (int e = 1; e <= 4000; e++) begin
            @(posedge clk); #1;
            if (done) begin
                done_at = e;
                break;
            end
            if (tt_valid && tt_ready) begin
                got_q.push_back(tt_data);
                got_last_q.push_back(tt_last);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({x_out, tt_data, onset_count, sig_out, busy, done, tt_valid, tt_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: x_out=%0d tt_data=%h onset=%0d sig=%h busy=%b done=%b valid=%b last=%b, required all zero",
                     x_out, tt_data, onset_count, sig_out, busy, done, tt_valid, tt_last);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b required 0", busy);
        end
    endtask

    task automatic test_zero();
        int done_at;
        logic [31:0] e, g;
        logic el, gl;
        mode = 0;
        push_expected(mode);
        do_start();
        collect(done_at);
        checks++;
        if (done_at != 513) begin
            errors++;
            $display("FAIL zero_latency: done after %0d edges, required 513", done_at);
        end
        checks++;
        if (got_q.size() != WORDS) begin
            errors++;
            $display("FAIL zero_word_count: got %0d words, required %0d", got_q.size(), WORDS);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if (g !== e || gl !== el) begin
                errors++;
                $display("FAIL zero_word: data=%h last=%b, required data=%h last=%b", g, gl, e, el);
            end
        end
        checks++;
        if (onset_count !== 10'd0) begin
            errors++;
            $display("FAIL zero_onset: onset=%0d required 0", onset_count);
        end
    endtask

    task automatic test_ones();
        int done_at;
        logic [31:0] e, g;
        logic el, gl;
        mode = 1;
        push_expected(mode);
        do_start();
        collect(done_at);
        checks++;
        if (got_q.size() != WORDS || done_at != 513) begin
            errors++;
            $display("FAIL ones_count: words=%0d done_at=%0d, required %0d and 513",
                     got_q.size(), done_at, WORDS);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if (g !== e || gl !== el) begin
                errors++;
                $display("FAIL ones_word: data=%h last=%b, required data=%h last=%b", g, gl, e, el);
            end
        end
        checks++;
        if (onset_count !== 10'd512) begin
            errors++;
            $display("FAIL ones_onset: onset=%0d required 512", onset_count);
        end
        // Results hold in IDLE until the next start
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (onset_count !== 10'd512 || tt_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL ones_hold: onset=%0d data=%h, required 512 and ffffffff",
                     onset_count, tt_data);
        end
    endtask

    task automatic test_x0_x8();
        int done_at;
        logic [31:0] e, g;
        logic el, gl;
        for (int m = 2; m <= 3; m++) begin
            mode = m;
            push_expected(mode);
            do_start();
            collect(done_at);
            checks++;
            if (got_q.size() != WORDS || done_at != 513) begin
                errors++;
                $display("FAIL pattern%0d_count: words=%0d done_at=%0d", m, got_q.size(), done_at);
            end
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                e = exp_q.pop_front(); g = got_q.pop_front();
                el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
                checks++;
                if (g !== e || gl !== el) begin
                    errors++;
                    $display("FAIL pattern%0d_word: data=%h last=%b, required data=%h last=%b",
                             m, g, gl, e, el);
                end
            end
            checks++;
            if (onset_count !== 10'd256) begin
                errors++;
                $display("FAIL pattern%0d_onset: onset=%0d required 256", m, onset_count);
            end
        end
    endtask

    task automatic test_stall();
        int done_at;
        logic [31:0] held, e, g;
        logic el, gl;
        mode = 2;
        push_expected(mode);
        tt_ready = 1'b0;
        do_start();
        held = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (i == 40) held = tt_data;
        end
        checks++;
        if (x_out !== 9'd63 || tt_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_freeze: x_out=%0d valid=%b busy=%b, required 63 1 1",
                     x_out, tt_valid, busy);
        end
        checks++;
        if (tt_data !== 32'hAAAA_AAAA || held !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL stall_hold: data@40=%h data@100=%h, required aaaaaaaa", held, tt_data);
        end
        tt_ready = 1'b1;
        got_q.push_back(tt_data);
        got_last_q.push_back(tt_last);
        collect(done_at);
        checks++;
        if (got_q.size() != WORDS || done_at < 0) begin
            errors++;
            $display("FAIL stall_count: words=%0d done_at=%0d", got_q.size(), done_at);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if (g !== e || gl !== el) begin
                errors++;
                $display("FAIL stall_word: data=%h last=%b, required data=%h last=%b", g, gl, e, el);
            end
        end
        checks++;
        if (onset_count !== 10'd256) begin
            errors++;
            $display("FAIL stall_onset: onset=%0d required 256", onset_count);
        end
    endtask

    task automatic test_start_and_reset();
        int done_at;
        int valid_seen;
        logic [31:0] e, g;
        logic el, gl;
        mode = 2;
        // Start pulse in SWEEP must not restart the walk
        push_expected(mode);
        do_start();
        repeat (20) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (x_out !== 9'd21 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored: x_out=%0d busy=%b, required 21 1", x_out, busy);
        end
        collect(done_at);
        checks++;
        if (got_q.size() != WORDS || done_at < 0) begin
            errors++;
            $display("FAIL start_ignored_count: words=%0d done_at=%0d", got_q.size(), done_at);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if (g !== e || gl !== el) begin
                errors++;
                $display("FAIL start_ignored_word: data=%h last=%b, required data=%h last=%b",
                         g, gl, e, el);
            end
        end
        // Asynchronous reset mid-sweep
        do_start();
        for (int i = 0; i < 600 && x_out != 9'd200; i++) begin @(posedge clk); #1; end
        checks++;
        if (x_out !== 9'd200) begin
            errors++;
            $display("FAIL reach_200: x_out=%0d required 200", x_out);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({x_out, tt_data, onset_count, sig_out, busy, done, tt_valid, tt_last} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: x_out=%0d data=%h onset=%0d sig=%h busy=%b valid=%b last=%b, required all zero",
                     x_out, tt_data, onset_count, sig_out, busy, tt_valid, tt_last);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        valid_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (tt_valid || busy) valid_seen++;
        end
        checks++;
        if (valid_seen != 0) begin
            errors++;
            $display("FAIL midreset_quiet: %0d cycles with valid/busy, required 0", valid_seen);
        end
        push_expected(mode);
        do_start();
        collect(done_at);
        checks++;
        if (got_q.size() != WORDS || done_at != 513) begin
            errors++;
            $display("FAIL fresh_count: words=%0d done_at=%0d, required %0d and 513",
                     got_q.size(), done_at, WORDS);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if (g !== e || gl !== el) begin
                errors++;
                $display("FAIL fresh_word: data=%h last=%b, required data=%h last=%b", g, gl, e, el);
            end
        end
    endtask

    task automatic test_real_pla();
        int done_at;
        logic [31:0] e, g;
        logic el, gl;
        logic [15:0] exp_sig;
        mode = 4;
        push_expected(mode);
        do_start();
        collect(done_at);
        checks++;
        if (got_q.size() != WORDS || done_at != 513) begin
            errors++;
            $display("FAIL pla_count: words=%0d done_at=%0d", got_q.size(), done_at);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
            checks++;
            if (g !== e || gl !== el) begin
                errors++;
                $display("FAIL pla_word: data=%h last=%b, required data=%h last=%b", g, gl, e, el);
            end
        end
        checks++;
        if (int'(onset_count) != model_onset(mode)) begin
            errors++;
            $display("FAIL pla_onset: onset=%0d required %0d", onset_count, model_onset(mode));
        end
`ifdef SWEEP_SIG_EN
        exp_sig = model_sig(mode);
`else
        exp_sig = 16'h0000;
`endif
        checks++;
        if (sig_out !== exp_sig) begin
            errors++;
            $display("FAIL pla_sig: sig_out=%h required %h", sig_out, exp_sig);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_ones();
        test_x0_x8();
        test_stall();
        test_start_and_reset();
        test_real_pla();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
